// File: rtl/vector_dot_product_pkg.sv
// Shared library package: neuron-vector geometry and element type used by the
// vector stages (scalar expansion, dot product, elementwise ops).
package vector_dot_product_pkg;

  localparam int MAX_NEURONS = 8;
  localparam int IDX_W       = $clog2(MAX_NEURONS + 1);
  localparam int SEL_W       = $clog2(MAX_NEURONS);

  typedef logic signed [31:0] elem_t;
  typedef elem_t [MAX_NEURONS-1:0] arr_t;

endpackage

// File: rtl/vector_dot_product_fixed_mul.sv
// Signed 32x32 fixed-point multiply: full 64-bit product, arithmetic shift
// right by FRAC_BITS, low 32 bits kept (no rounding, no saturation).
module fixed_mul #(
  parameter int FRAC_BITS = 0
) (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] p
);

  logic signed [63:0] full;
  logic signed [63:0] shifted;

  assign full    = 64'(a) * 64'(b);
  assign shifted = full >>> FRAC_BITS;
  assign p       = shifted[31:0];

endmodule

// File: rtl/vector_dot_product.sv
// Sequential dot-product engine: one element pair per cycle, accumulating
// into a wrapping 32-bit register, with valid/ready on both sides.
module vector_dot_product
  import vector_dot_product_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  arr_t               vec_a,
  input  arr_t               vec_b,
  input  logic signed [31:0] length,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] result
);

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds its payload until then.

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  arr_t               a_reg;
  arr_t               b_reg;
  logic [IDX_W-1:0]   len;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   eff_len;
  logic signed [31:0] acc;
  logic signed [31:0] prod;

  always_comb begin
    eff_len = '0;
    if (length < 0)
      eff_len = '0;
    else if (length > MAX_NEURONS)
      eff_len = IDX_W'(MAX_NEURONS);
    else
      eff_len = length[IDX_W-1:0];
  end

  fixed_mul #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .a (a_reg[idx[SEL_W-1:0]]),
    .b (b_reg[idx[SEL_W-1:0]]),
    .p (prod)
  );

  // in_ready and out_valid are registered alongside state, so they are
  // exact decodes of IDLE and DONE with no path from out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      len       <= '0;
      idx       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= vec_a;
            b_reg    <= vec_b;
            len      <= eff_len;
            idx      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            if (eff_len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc + prod;
          idx <= idx + IDX_W'(1);
          if (idx == len - IDX_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_vector_dot_product.sv
// Directed bench for vector_dot_product: two instances (FRAC_BITS 0 and 8),
// expected results queued at issue time and checked by output monitors.
module tb_vector_dot_product;
  import vector_dot_product_pkg::*;

  logic               clk;
  logic               reset;
  logic               in_valid0, in_valid8;
  logic               in_ready0, in_ready8;
  logic               out_valid0, out_valid8;
  logic               out_ready0, out_ready8;
  logic signed [31:0] result0, result8;
  arr_t               va, vb;
  logic signed [31:0] length;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q8[$];

  vector_dot_product #(.FRAC_BITS(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .vec_a(va), .vec_b(vb), .length(length), .out_valid(out_valid0),
    .out_ready(out_ready0), .result(result0)
  );

  vector_dot_product #(.FRAC_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .vec_a(va), .vec_b(vb), .length(length), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // monitors: pop and compare on every output handshake
  always begin
    @(negedge clk);
    #1;
    if (!reset && out_valid0 && out_ready0) begin
      if (exp_q0.size() == 0) check("unexpected_out0", result0, 32'hxxxxxxxx);
      else check("result0", result0, exp_q0.pop_front());
    end
    if (!reset && out_valid8 && out_ready8) begin
      if (exp_q8.size() == 0) check("unexpected_out8", result8, 32'hxxxxxxxx);
      else check("result8", result8, exp_q8.pop_front());
    end
  end

  task automatic load_seq(input int a0, input int b0);
    for (int i = 0; i < MAX_NEURONS; i++) begin
      va[i] = a0 + i;
      vb[i] = b0 + i;
    end
  endtask

  // drive one request; lat>=0 checks out_valid rises exactly lat cycles later
  task automatic issue(input int len, input logic [31:0] exp, input bit frac,
                       input bit push, input int lat);
    int c;
    bit got;
    @(negedge clk);
    length = len;
    if (frac) in_valid8 = 1'b1; else in_valid0 = 1'b1;
    c = 0;
    while (!(frac ? in_ready8 : in_ready0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    if (push) begin
      if (frac) exp_q8.push_back(exp); else exp_q0.push_back(exp);
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid8 = 1'b0;
    if (lat >= 0) begin
      c = 1;
      got = frac ? out_valid8 : out_valid0;
      while (!got && c < 40) begin
        @(negedge clk);
        c++;
        got = frac ? out_valid8 : out_valid0;
      end
      check("latency", 32'(c), 32'(lat));
      @(negedge clk);
      check("out_valid_one_cycle", {31'd0, frac ? out_valid8 : out_valid0}, 32'd0);
      check("in_ready_after", {31'd0, frac ? in_ready8 : in_ready0}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] held;
    int w;
    reset = 1'b1; in_valid0 = 1'b0; in_valid8 = 1'b0;
    out_ready0 = 1'b1; out_ready8 = 1'b1; length = 0;
    va = '0; vb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state over 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle0", {in_ready0, out_valid0, 30'd0}, {1'b1, 1'b0, 30'd0});
      check("reset_result0", result0, 32'd0);
    end
    check("reset_idle8", {in_ready8, out_valid8, 30'd0}, {1'b1, 1'b0, 30'd0});

    // [1..] . [5..], length 4 -> 5+12+21+32
    load_seq(1, 5);
    issue(4, 32'd70, 1'b0, 1'b1, 5);
    // full length 8 -> sum(i*(i+4)) = 204 + 144
    issue(8, 32'd348, 1'b0, 1'b1, 9);
    // zero and negative lengths
    issue(0, 32'd0, 1'b0, 1'b1, 1);
    issue(-3, 32'd0, 1'b0, 1'b1, 1);
    // over-long length clamps to MAX_NEURONS
    for (int i = 0; i < MAX_NEURONS; i++) begin va[i] = 1; vb[i] = 1; end
    issue(MAX_NEURONS + 5, 32'd8, 1'b0, 1'b1, 9);
    // signed: -7*6 = -42
    va[0] = -7; vb[0] = 6;
    issue(1, 32'hFFFFFFD6, 1'b0, 1'b1, 2);
    // wrap: 0x7FFFFFFF^2 low word is 1, two of them -> 2
    va[0] = 32'h7FFFFFFF; va[1] = 32'h7FFFFFFF;
    vb[0] = 32'h7FFFFFFF; vb[1] = 32'h7FFFFFFF;
    issue(2, 32'd2, 1'b0, 1'b1, 3);
    // Q.8 fixed point: 1.5 * -2.0 = -3.0
    va[0] = 32'h00000180; vb[0] = 32'hFFFFFE00;
    issue(1, 32'hFFFFFD00, 1'b1, 1'b1, 2);

    // backpressure: 10+40+90 held for 6 cycles, new requests ignored
    va = '0; vb = '0;
    va[0] = 10; va[1] = 20; va[2] = 30;
    vb[0] = 1;  vb[1] = 2;  vb[2] = 3;
    out_ready0 = 1'b0;
    issue(3, 32'd140, 1'b0, 1'b1, -1);
    w = 0;
    while (!out_valid0 && w < 20) begin @(negedge clk); w++; end
    check("stall_reach_done", {31'd0, out_valid0}, 32'd1);
    held = result0;
    check("stall_value", held, 32'd140);
    length = 1; va[0] = 99; in_valid0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid0}, 32'd1);
      check("stall_result", result0, held);
      check("stall_in_ready", {31'd0, in_ready0}, 32'd0);
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    #2;
    check("handshake_in_ready", {31'd0, in_ready0}, 32'd0);
    @(negedge clk);
    check("post_stall_in_ready", {31'd0, in_ready0}, 32'd1);
    check("post_stall_valid", {31'd0, out_valid0}, 32'd0);

    // reset on the second RUN cycle aborts the request
    load_seq(1, 5);
    @(negedge clk);
    length = 4; in_valid0 = 1'b1;
    @(negedge clk);            // handshake edge passed: RUN cycle 1
    in_valid0 = 1'b0;
    @(negedge clk);            // RUN cycle 2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", {31'd0, out_valid0}, 32'd0);
    end
    check("abort_in_ready", {31'd0, in_ready0}, 32'd1);
    // next request: -1*4 + 2*3 + -3*2 = -4
    va[0] = -1; va[1] = 2; va[2] = -3;
    vb[0] = 4;  vb[1] = 3; vb[2] = 2;
    issue(3, 32'hFFFFFFFC, 1'b0, 1'b1, 4);

    w = 0;
    while ((exp_q0.size() != 0 || exp_q8.size() != 0) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q8", 32'(exp_q8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
